// File: rtl/kinase_valve_sequencer_if.sv
// -----------------------------------------------------------------------------
// kinase_valve_sequencer_if
//
// Purpose:
//   Command channel into the kinase_valve_sequencer. A producer presents one
//   step command (valve pattern + pump timing) and holds it with cmd_valid
//   until the sequencer raises cmd_ready. The command is taken on the clock
//   edge where both are high.
//
// Signals:
//   cmd_valid      producer -> sequencer   command valid
//   cmd_ready      sequencer -> producer   sequencer idle, can take a command
//   cmd_ctrl_a     [12:0]                  ctrl_a valve pattern
//   cmd_ctrl_s     [3:0]                   ctrl_s valve pattern
//   cmd_strokes    [STROKE_W-1:0]          full pump strokes, 0 = no pumping
//   cmd_phase_div  [PHASE_W-1:0]           cycles per pump phase, 0 acts as 1
//   cmd_dwell      [DWELL_W-1:0]           post-pump hold cycles, 0 = none
//   cmd_pump_b_en                          drive pump_b during pumping
//   cmd_reverse                            run the pump backwards (only present
//                                          when KINASE_SEQ_REVERSE_EN is defined)
//
// Modports:
//   master  command producer
//   slave   the sequencer
//
// Optional feature macro: KINASE_SEQ_REVERSE_EN
// -----------------------------------------------------------------------------
interface kinase_valve_sequencer_if #(
   parameter int PHASE_W  = 16,
   parameter int STROKE_W = 12,
   parameter int DWELL_W  = 24
);
   logic                cmd_valid;
   logic                cmd_ready;
   logic [12:0]         cmd_ctrl_a;
   logic [3:0]          cmd_ctrl_s;
   logic [STROKE_W-1:0] cmd_strokes;
   logic [PHASE_W-1:0]  cmd_phase_div;
   logic [DWELL_W-1:0]  cmd_dwell;
   logic                cmd_pump_b_en;
`ifdef KINASE_SEQ_REVERSE_EN
   logic                cmd_reverse;

   modport master (
      output cmd_valid, cmd_ctrl_a, cmd_ctrl_s, cmd_strokes, cmd_phase_div,
             cmd_dwell, cmd_pump_b_en, cmd_reverse,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_ctrl_a, cmd_ctrl_s, cmd_strokes, cmd_phase_div,
             cmd_dwell, cmd_pump_b_en, cmd_reverse,
      output cmd_ready
   );
`else
   modport master (
      output cmd_valid, cmd_ctrl_a, cmd_ctrl_s, cmd_strokes, cmd_phase_div,
             cmd_dwell, cmd_pump_b_en,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_ctrl_a, cmd_ctrl_s, cmd_strokes, cmd_phase_div,
             cmd_dwell, cmd_pump_b_en,
      output cmd_ready
   );
`endif
endinterface

// File: rtl/kinase_valve_sequencer.sv
// -----------------------------------------------------------------------------
// kinase_valve_sequencer
//
// Purpose:
//   Drives the pneumatic control pads of the kinase_activity pad array. Each
//   accepted command applies a ctrl_a/ctrl_s valve pattern, waits a fixed
//   settle time, runs a timed six-phase peristaltic pump sequence for the
//   commanded number of strokes, then dwells before returning to idle.
//   Logic 1 on a pad = valve pressurized (closed).
//
// Sequence per command:  IDLE -> SETTLE -> PUMP -> DWELL -> IDLE
//   SETTLE lasts SETTLE_CYCLES cycles (skipped when 0).
//   PUMP runs strokes*6 phases, then one extra cycle with the pumps vented
//   (skipped entirely when strokes = 0).
//   DWELL lasts cmd_dwell cycles (skipped when 0).
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   cmd          command channel (kinase_valve_sequencer_if.slave)
//   abort        synchronous abort; returns to IDLE with all pads vented
//   pad_ctrl_a   [12:0] ctrl_a pad drive (holds last pattern in IDLE)
//   pad_ctrl_s   [3:0]  ctrl_s pad drive (holds last pattern in IDLE)
//   pad_pump_a   [2:0]  pump_a pad drive
//   pad_pump_b   [1:0]  pump_b pad drive
//   busy         high in any state other than IDLE
//   done         one-cycle pulse in the cycle IDLE is re-entered normally
//   aborted      one-cycle pulse when an active command is aborted
//   stroke_cnt   strokes completed in the current or last command
//
// Optional feature macro: KINASE_SEQ_REVERSE_EN
//   When defined, cmd.cmd_reverse selects a backwards pump walk (and swapped
//   pump_b halves). When undefined the pump always runs forward.
// -----------------------------------------------------------------------------
module kinase_valve_sequencer #(
   parameter int PHASE_W       = 16,
   parameter int STROKE_W      = 12,
   parameter int DWELL_W       = 24,
   parameter int SETTLE_CYCLES = 1000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   kinase_valve_sequencer_if.slave   cmd,
   input  logic                      abort,
   output logic [12:0]               pad_ctrl_a,
   output logic [3:0]                pad_ctrl_s,
   output logic [2:0]                pad_pump_a,
   output logic [1:0]                pad_pump_b,
   output logic                      busy,
   output logic                      done,
   output logic                      aborted,
   output logic [STROKE_W-1:0]       stroke_cnt
);

   // One shared cycle timer serves settle, phase hold and dwell, so it is as
   // wide as the widest of the three limits.
   localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int PD_W     = (PHASE_W > DWELL_W) ? PHASE_W : DWELL_W;
   localparam int TMR_W    = (PD_W > SETTLE_W) ? PD_W : SETTLE_W;
   localparam logic [TMR_W-1:0] SETTLE_LAST =
      (SETTLE_CYCLES > 0) ? TMR_W'(SETTLE_CYCLES - 1) : '0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      PUMP   = 2'd2,
      DWELL  = 2'd3
   } state_t;

   state_t              state_reg,      state_next;
   logic [TMR_W-1:0]    timer_reg,      timer_next;
   logic [2:0]          phase_reg,      phase_next;
   logic                pump_off_reg,   pump_off_next;
   logic [STROKE_W-1:0] stroke_cnt_reg, stroke_cnt_next;
   logic [STROKE_W-1:0] strokes_reg,    strokes_next;
   logic [PHASE_W-1:0]  phase_last_reg, phase_last_next;
   logic [DWELL_W-1:0]  dwell_reg,      dwell_next;
   logic                pump_b_en_reg,  pump_b_en_next;
   logic                reverse_reg,    reverse_next;
   logic [12:0]         ctrl_a_reg,     ctrl_a_next;
   logic [3:0]          ctrl_s_reg,     ctrl_s_next;
   logic                done_reg,       done_next;
   logic                aborted_reg,    aborted_next;

   logic [2:0]          seq_idx;
   logic [2:0]          pump_a_dec;
   logic [1:0]          pump_b_dec;

   // Where to go once settling is over: pumping if there are strokes, else
   // dwelling if there is a dwell, else straight back to idle.
   function automatic state_t after_settle(input logic [STROKE_W-1:0] strokes,
                                           input logic [DWELL_W-1:0]  dwell);
      if (strokes != '0)
         return PUMP;
      else if (dwell != '0)
         return DWELL;
      else
         return IDLE;
   endfunction

   // -------------------------------------------------------------------------
   // State and datapath registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         timer_reg      <= '0;
         phase_reg      <= '0;
         pump_off_reg   <= 1'b0;
         stroke_cnt_reg <= '0;
         strokes_reg    <= '0;
         phase_last_reg <= '0;
         dwell_reg      <= '0;
         pump_b_en_reg  <= 1'b0;
         reverse_reg    <= 1'b0;
         ctrl_a_reg     <= '0;
         ctrl_s_reg     <= '0;
         done_reg       <= 1'b0;
         aborted_reg    <= 1'b0;
      end else begin
         state_reg      <= state_next;
         timer_reg      <= timer_next;
         phase_reg      <= phase_next;
         pump_off_reg   <= pump_off_next;
         stroke_cnt_reg <= stroke_cnt_next;
         strokes_reg    <= strokes_next;
         phase_last_reg <= phase_last_next;
         dwell_reg      <= dwell_next;
         pump_b_en_reg  <= pump_b_en_next;
         reverse_reg    <= reverse_next;
         ctrl_a_reg     <= ctrl_a_next;
         ctrl_s_reg     <= ctrl_s_next;
         done_reg       <= done_next;
         aborted_reg    <= aborted_next;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_next      = state_reg;
      timer_next      = timer_reg;
      phase_next      = phase_reg;
      pump_off_next   = pump_off_reg;
      stroke_cnt_next = stroke_cnt_reg;
      strokes_next    = strokes_reg;
      phase_last_next = phase_last_reg;
      dwell_next      = dwell_reg;
      pump_b_en_next  = pump_b_en_reg;
      reverse_next    = reverse_reg;
      ctrl_a_next     = ctrl_a_reg;
      ctrl_s_next     = ctrl_s_reg;
      done_next       = 1'b0;
      aborted_next    = 1'b0;

      if (abort) begin
         // Abort wins over everything, including a command offered in IDLE.
         // stroke_cnt is left untouched so the host can see how far it got.
         state_next    = IDLE;
         timer_next    = '0;
         phase_next    = '0;
         pump_off_next = 1'b0;
         ctrl_a_next   = '0;
         ctrl_s_next   = '0;
         aborted_next  = (state_reg != IDLE);
      end else begin
         case (state_reg)
            IDLE: begin
               if (cmd.cmd_valid) begin
                  strokes_next    = cmd.cmd_strokes;
                  // Store the last count of a phase; a divider of 0 behaves as 1.
                  phase_last_next = (cmd.cmd_phase_div == '0) ? '0
                                    : cmd.cmd_phase_div - PHASE_W'(1);
                  dwell_next      = cmd.cmd_dwell;
                  pump_b_en_next  = cmd.cmd_pump_b_en;
`ifdef KINASE_SEQ_REVERSE_EN
                  reverse_next    = cmd.cmd_reverse;
`else
                  reverse_next    = 1'b0;
`endif
                  ctrl_a_next     = cmd.cmd_ctrl_a;
                  ctrl_s_next     = cmd.cmd_ctrl_s;
                  stroke_cnt_next = '0;
                  timer_next      = '0;
                  phase_next      = '0;
                  pump_off_next   = 1'b0;
                  if (SETTLE_CYCLES > 0) begin
                     state_next = SETTLE;
                  end else begin
                     state_next = after_settle(cmd.cmd_strokes, cmd.cmd_dwell);
                     done_next  = (state_next == IDLE);
                  end
               end
            end

            SETTLE: begin
               if (timer_reg == SETTLE_LAST) begin
                  timer_next = '0;
                  state_next = after_settle(strokes_reg, dwell_reg);
                  done_next  = (state_next == IDLE);
               end else begin
                  timer_next = timer_reg + TMR_W'(1);
               end
            end

            PUMP: begin
               if (pump_off_reg) begin
                  // Pumps have had their one vented cycle; move on.
                  pump_off_next = 1'b0;
                  timer_next    = '0;
                  phase_next    = '0;
                  if (dwell_reg != '0) begin
                     state_next = DWELL;
                  end else begin
                     state_next = IDLE;
                     done_next  = 1'b1;
                  end
               end else if (timer_reg == TMR_W'(phase_last_reg)) begin
                  timer_next = '0;
                  if (phase_reg == 3'd5) begin
                     phase_next      = '0;
                     stroke_cnt_next = stroke_cnt_reg + STROKE_W'(1);
                     // Last stroke finished: vent the pumps for one cycle
                     // before leaving PUMP.
                     if (stroke_cnt_reg + STROKE_W'(1) == strokes_reg)
                        pump_off_next = 1'b1;
                  end else begin
                     phase_next = phase_reg + 3'd1;
                  end
               end else begin
                  timer_next = timer_reg + TMR_W'(1);
               end
            end

            DWELL: begin
               if (timer_reg == TMR_W'(dwell_reg - DWELL_W'(1))) begin
                  timer_next = '0;
                  state_next = IDLE;
                  done_next  = 1'b1;
               end else begin
                  timer_next = timer_reg + TMR_W'(1);
               end
            end

            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Pump pattern decode
   //   A backwards walk visits the forward table from the end, so reverse is
   //   just an index mirror; the pump_b halves mirror with it.
   // -------------------------------------------------------------------------
   always_comb begin
      seq_idx    = reverse_reg ? (3'd5 - phase_reg) : phase_reg;
      pump_a_dec = 3'b000;
      pump_b_dec = 2'b00;
      if ((state_reg == PUMP) && !pump_off_reg) begin
         case (seq_idx)
            3'd0:    pump_a_dec = 3'b101;
            3'd1:    pump_a_dec = 3'b100;
            3'd2:    pump_a_dec = 3'b110;
            3'd3:    pump_a_dec = 3'b010;
            3'd4:    pump_a_dec = 3'b011;
            3'd5:    pump_a_dec = 3'b001;
            default: pump_a_dec = 3'b000;
         endcase
         if (pump_b_en_reg)
            pump_b_dec = (seq_idx < 3'd3) ? 2'b10 : 2'b01;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign cmd.cmd_ready = (state_reg == IDLE);
   assign busy          = (state_reg != IDLE);
   assign done          = done_reg;
   assign aborted       = aborted_reg;
   assign stroke_cnt    = stroke_cnt_reg;
   assign pad_ctrl_a    = ctrl_a_reg;
   assign pad_ctrl_s    = ctrl_s_reg;
   assign pad_pump_a    = pump_a_dec;
   assign pad_pump_b    = pump_b_dec;

endmodule

// File: tb/tb_kinase_valve_sequencer.sv
// -----------------------------------------------------------------------------
// tb_kinase_valve_sequencer
//
// Bench for kinase_valve_sequencer with SETTLE_CYCLES = 4. Every accepted
// command is expanded into the full cycle-by-cycle list of expected pad and
// status values; a compare process checks the DUT against the head of that
// list on every falling edge. Directed scenarios add literal expectations,
// then a randomized phase mixes commands, idle gaps and aborts.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_kinase_valve_sequencer;

   localparam int PHASE_W       = 16;
   localparam int STROKE_W      = 12;
   localparam int DWELL_W       = 24;
   localparam int SETTLE_CYCLES = 4;

   logic                clk   = 1'b0;
   logic                rst_n = 1'b0;
   logic                abort = 1'b0;
   logic [12:0]         pad_ctrl_a;
   logic [3:0]          pad_ctrl_s;
   logic [2:0]          pad_pump_a;
   logic [1:0]          pad_pump_b;
   logic                busy;
   logic                done;
   logic                aborted;
   logic [STROKE_W-1:0] stroke_cnt;

   kinase_valve_sequencer_if #(
      .PHASE_W (PHASE_W),
      .STROKE_W(STROKE_W),
      .DWELL_W (DWELL_W)
   ) cmd_bus ();

   kinase_valve_sequencer #(
      .PHASE_W      (PHASE_W),
      .STROKE_W     (STROKE_W),
      .DWELL_W      (DWELL_W),
      .SETTLE_CYCLES(SETTLE_CYCLES)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd       (cmd_bus),
      .abort     (abort),
      .pad_ctrl_a(pad_ctrl_a),
      .pad_ctrl_s(pad_ctrl_s),
      .pad_pump_a(pad_pump_a),
      .pad_pump_b(pad_pump_b),
      .busy      (busy),
      .done      (done),
      .aborted   (aborted),
      .stroke_cnt(stroke_cnt)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // -------------------------------------------------------------------------
   // Reference model: expected values for every cycle
   // -------------------------------------------------------------------------
   typedef struct {
      logic [12:0]         ca;
      logic [3:0]          cs;
      logic [2:0]          pa;
      logic [1:0]          pb;
      logic                bsy;
      logic                dn;
      logic                ab;
      logic [STROKE_W-1:0] sc;
   } frame_t;

   frame_t exp_q[$];
   frame_t cur;

   logic [2:0] fwd_seq [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
   logic [2:0] rev_seq [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};

   function automatic frame_t mk(input logic [12:0] ca, input logic [3:0] cs,
                                 input logic [2:0] pa, input logic [1:0] pb,
                                 input logic bsy, input logic dn, input logic ab,
                                 input logic [STROKE_W-1:0] sc);
      frame_t f;
      f.ca = ca; f.cs = cs; f.pa = pa; f.pb = pb;
      f.bsy = bsy; f.dn = dn; f.ab = ab; f.sc = sc;
      return f;
   endfunction

   // Timeline of one command, starting with the cycle after acceptance.
   task automatic expand(input logic [12:0] ca, input logic [3:0] cs, input int strokes,
                         input int div, input int dwell, input logic ben, input logic rev);
      int         len;
      logic [2:0] pa;
      logic [1:0] pb;
      len = (div == 0) ? 1 : div;
      for (int i = 0; i < SETTLE_CYCLES; i++)
         exp_q.push_back(mk(ca, cs, 3'b000, 2'b00, 1'b1, 1'b0, 1'b0, '0));
      for (int k = 0; k < strokes; k++) begin
         for (int p = 0; p < 6; p++) begin
            pa = rev ? rev_seq[p] : fwd_seq[p];
            if (!ben)
               pb = 2'b00;
            else if (!rev)
               pb = (p < 3) ? 2'b10 : 2'b01;
            else
               pb = (p < 3) ? 2'b01 : 2'b10;
            for (int c = 0; c < len; c++)
               exp_q.push_back(mk(ca, cs, pa, pb, 1'b1, 1'b0, 1'b0, STROKE_W'(k)));
         end
      end
      if (strokes > 0)
         exp_q.push_back(mk(ca, cs, 3'b000, 2'b00, 1'b1, 1'b0, 1'b0, STROKE_W'(strokes)));
      for (int d = 0; d < dwell; d++)
         exp_q.push_back(mk(ca, cs, 3'b000, 2'b00, 1'b1, 1'b0, 1'b0, STROKE_W'(strokes)));
      exp_q.push_back(mk(ca, cs, 3'b000, 2'b00, 1'b0, 1'b1, 1'b0, STROKE_W'(strokes)));
   endtask

   initial begin
      logic rev;
      cur = mk('0, '0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            exp_q.delete();
            cur = mk('0, '0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
         end else if (abort) begin
            if (cur.bsy)
               $display("[%0t] abort at stroke_cnt=%0d", $time, cur.sc);
            exp_q.delete();
            cur = mk('0, '0, '0, '0, 1'b0, 1'b0, cur.bsy, cur.sc);
         end else if (!cur.bsy && cmd_bus.cmd_valid) begin
`ifdef KINASE_SEQ_REVERSE_EN
            rev = cmd_bus.cmd_reverse;
`else
            rev = 1'b0;
`endif
            $display("[%0t] accept ctrl_a=%h ctrl_s=%h strokes=%0d div=%0d dwell=%0d pump_b_en=%0b rev=%0b",
                     $time, cmd_bus.cmd_ctrl_a, cmd_bus.cmd_ctrl_s, cmd_bus.cmd_strokes,
                     cmd_bus.cmd_phase_div, cmd_bus.cmd_dwell, cmd_bus.cmd_pump_b_en, rev);
            expand(cmd_bus.cmd_ctrl_a, cmd_bus.cmd_ctrl_s, int'(cmd_bus.cmd_strokes),
                   int'(cmd_bus.cmd_phase_div), int'(cmd_bus.cmd_dwell),
                   cmd_bus.cmd_pump_b_en, rev);
            cur = exp_q.pop_front();
         end else if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
         end else begin
            cur = mk(cur.ca, cur.cs, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, cur.sc);
         end
         if (cur.dn)
            $display("[%0t] done stroke_cnt=%0d", $time, cur.sc);
      end
   end

   // Cycle-by-cycle compare against the model
   initial begin
      forever begin
         @(negedge clk);
         check("pad_ctrl_a", 32'(pad_ctrl_a), 32'(cur.ca));
         check("pad_ctrl_s", 32'(pad_ctrl_s), 32'(cur.cs));
         check("pad_pump_a", 32'(pad_pump_a), 32'(cur.pa));
         check("pad_pump_b", 32'(pad_pump_b), 32'(cur.pb));
         check("busy",       32'(busy),       32'(cur.bsy));
         check("cmd_ready",  32'(cmd_bus.cmd_ready), 32'(!cur.bsy));
         check("done",       32'(done),       32'(cur.dn));
         check("aborted",    32'(aborted),    32'(cur.ab));
         check("stroke_cnt", 32'(stroke_cnt), 32'(cur.sc));
      end
   end

   // -------------------------------------------------------------------------
   // Stimulus helpers
   // -------------------------------------------------------------------------
   logic [2:0]          seen_pa [0:127];
   logic [1:0]          seen_pb [0:127];
   logic [STROKE_W-1:0] seen_sc [0:127];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_cmd(input logic [12:0] ca, input logic [3:0] cs, input int strokes,
                            input int div, input int dwell, input logic ben);
      cmd_bus.cmd_valid     = 1'b1;
      cmd_bus.cmd_ctrl_a    = ca;
      cmd_bus.cmd_ctrl_s    = cs;
      cmd_bus.cmd_strokes   = STROKE_W'(strokes);
      cmd_bus.cmd_phase_div = PHASE_W'(div);
      cmd_bus.cmd_dwell     = DWELL_W'(dwell);
      cmd_bus.cmd_pump_b_en = ben;
`ifdef KINASE_SEQ_REVERSE_EN
      cmd_bus.cmd_reverse   = 1'b0;
`endif
   endtask

   // Put garbage on the command fields; the DUT must not pick any of it up.
   task automatic scramble(input logic keep_valid);
      cmd_bus.cmd_valid     = keep_valid;
      cmd_bus.cmd_ctrl_a    = 13'($urandom);
      cmd_bus.cmd_ctrl_s    = 4'($urandom);
      cmd_bus.cmd_strokes   = STROKE_W'($urandom_range(0, 3));
      cmd_bus.cmd_phase_div = PHASE_W'($urandom_range(0, 3));
      cmd_bus.cmd_dwell     = DWELL_W'($urandom_range(0, 4));
      cmd_bus.cmd_pump_b_en = 1'($urandom);
`ifdef KINASE_SEQ_REVERSE_EN
      cmd_bus.cmd_reverse   = 1'($urandom);
`endif
   endtask

   // Waits for done, recording the pump pads per cycle index (index 1 is the
   // cycle right after acceptance). n = -1 if the budget runs out.
   task automatic wait_done(input int first, input int budget, output int n);
      n = -1;
      for (int i = first; i <= budget; i++) begin
         @(negedge clk);
         seen_pa[i] = pad_pump_a;
         seen_pb[i] = pad_pump_b;
         seen_sc[i] = stroke_cnt;
         if (done) begin
            n = i;
            break;
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // -------------------------------------------------------------------------
   // Scenarios
   // -------------------------------------------------------------------------
   initial begin
      int   n;
      logic [4:0] pump_or;

      cmd_bus.cmd_valid     = 1'b0;
      cmd_bus.cmd_ctrl_a    = '0;
      cmd_bus.cmd_ctrl_s    = '0;
      cmd_bus.cmd_strokes   = '0;
      cmd_bus.cmd_phase_div = '0;
      cmd_bus.cmd_dwell     = '0;
      cmd_bus.cmd_pump_b_en = 1'b0;
`ifdef KINASE_SEQ_REVERSE_EN
      cmd_bus.cmd_reverse   = 1'b0;
`endif

      // 1: reset values
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("t1_pad_ctrl_a", 32'(pad_ctrl_a), 32'h0);
      check("t1_cmd_ready",  32'(cmd_bus.cmd_ready), 32'h1);
      check("t1_busy",       32'(busy), 32'h0);
      check("t1_stroke_cnt", 32'(stroke_cnt), 32'h0);

      // 2: full command
      drive_cmd(13'h1A5, 4'h9, 2, 3, 5, 1'b1);
      tick();
      scramble(1'b0);
      @(negedge clk);
      check("t2_ctrl_a_T1", 32'(pad_ctrl_a), 32'h1A5);
      check("t2_ctrl_s_T1", 32'(pad_ctrl_s), 32'h9);
      wait_done(2, 100, n);
      check("t2_done_latency", n, 47);
      check("t2_pump_a_first", 32'(seen_pa[5]), 32'b101);
      check("t2_pump_b_first", 32'(seen_pb[5]), 32'b10);
      check("t2_pump_a_ph1",   32'(seen_pa[8]), 32'b100);
      check("t2_pump_b_ph3",   32'(seen_pb[14]), 32'b01);
      check("t2_pump_a_ph5",   32'(seen_pa[20]), 32'b001);
      check("t2_stroke1_cnt",  32'(seen_sc[23]), 32'h1);
      check("t2_pump_off",     32'(seen_pa[41]), 32'b000);
      check("t2_final_cnt",    32'(stroke_cnt), 32'h2);

      // 3: no strokes, no dwell
      drive_cmd(13'h0F0, 4'h6, 0, 2, 0, 1'b1);
      tick();
      scramble(1'b0);
      wait_done(1, 100, n);
      check("t3_done_latency", n, 5);
      pump_or = '0;
      for (int i = 1; i <= ((n < 0) ? 100 : n); i++)
         pump_or = pump_or | {seen_pa[i], seen_pb[i]};
      check("t3_pumps_idle", 32'(pump_or), 32'h0);
      repeat (3) @(negedge clk);
      check("t3_ctrl_a_held", 32'(pad_ctrl_a), 32'h0F0);
      check("t3_ctrl_s_held", 32'(pad_ctrl_s), 32'h6);

      // 4: abort in phase 2 of the second stroke
      tick();
      drive_cmd(13'h0AA, 4'h3, 3, 2, 3, 1'b1);
      tick();
      scramble(1'b0);
      repeat (20) tick();
      abort = 1'b1;
      @(negedge clk);
      check("t4_pre_abort_pump_a", 32'(pad_pump_a), 32'b110);
      tick();
      abort = 1'b0;
      @(negedge clk);
      check("t4_aborted",    32'(aborted), 32'h1);
      check("t4_done",       32'(done), 32'h0);
      check("t4_stroke_cnt", 32'(stroke_cnt), 32'h1);
      check("t4_ctrl_a",     32'(pad_ctrl_a), 32'h0);
      check("t4_cmd_ready",  32'(cmd_bus.cmd_ready), 32'h1);
      @(negedge clk);
      check("t4_aborted_pulse", 32'(aborted), 32'h0);

      // 5: phase_div 0, back-to-back command with valid held
      tick();
      drive_cmd(13'h155, 4'hA, 1, 0, 0, 1'b0);
      tick();
      drive_cmd(13'h0C3, 4'h5, 1, 1, 2, 1'b1);
      wait_done(1, 100, n);
      check("t5_done_latency", n, 12);
      check("t5_pump_a_ph1",   32'(seen_pa[6]), 32'b100);
      check("t5_pump_a_ph5",   32'(seen_pa[10]), 32'b001);
      check("t5_pump_a_off",   32'(seen_pa[11]), 32'b000);
      tick();
      scramble(1'b0);
      @(negedge clk);
      check("t5_second_ctrl_a", 32'(pad_ctrl_a), 32'h0C3);
      check("t5_second_busy",   32'(busy), 32'h1);
      wait_done(2, 100, n);
      check("t5_second_latency", n, 14);

`ifdef KINASE_SEQ_REVERSE_EN
      // 6: reverse pump walk
      tick();
      drive_cmd(13'h011, 4'h1, 1, 1, 0, 1'b1);
      cmd_bus.cmd_reverse = 1'b1;
      tick();
      scramble(1'b0);
      wait_done(1, 100, n);
      check("t6_done_latency", n, 12);
      for (int p = 0; p < 6; p++)
         check("t6_rev_pump_a", 32'(seen_pa[5 + p]), 32'(rev_seq[p]));
      check("t6_rev_pump_b_first", 32'(seen_pb[5]), 32'b01);
      check("t6_rev_pump_b_last",  32'(seen_pb[8]), 32'b10);
`endif

      // Randomized phase: commands, gaps and aborts on every cycle
      for (int c = 0; c < 3000; c++) begin
         scramble($urandom_range(0, 3) == 0);
         abort = ($urandom_range(0, 59) == 0);
         tick();
      end
      abort = 1'b0;
      cmd_bus.cmd_valid = 1'b0;
      repeat (80) tick();

      // Asynchronous reset in the middle of a command
      drive_cmd(13'h1FF, 4'hF, 2, 2, 2, 1'b1);
      tick();
      scramble(1'b0);
      repeat (8) tick();
      #2 rst_n = 1'b0;
      #1;
      check("rst_busy",       32'(busy), 32'h0);
      check("rst_pump_a",     32'(pad_pump_a), 32'h0);
      check("rst_ctrl_a",     32'(pad_ctrl_a), 32'h0);
      check("rst_stroke_cnt", 32'(stroke_cnt), 32'h0);
      tick();
      rst_n = 1'b1;
      repeat (3) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
